// File: rtl/vga_pkg.sv
// Shared constants for the VGA box renderer: default resolution, colours,
// the box palette and the motion FSM state encoding.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [11:0] BG_DARK    = 12'h111;
    localparam logic [11:0] BG_LIGHT   = 12'h222;
    localparam logic [11:0] BORDER_RGB = 12'hFFF;

    typedef enum logic [1:0] {
        WAIT_VBLANK = 2'd0,
        UPDATE_X    = 2'd1,
        UPDATE_Y    = 2'd2,
        WAIT_ACTIVE = 2'd3
    } motion_state_e;

    function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hF00;
            3'd1:    rgb = 12'h0F0;
            3'd2:    rgb = 12'h00F;
            3'd3:    rgb = 12'hFF0;
            3'd4:    rgb = 12'h0FF;
            3'd5:    rgb = 12'hF0F;
            3'd6:    rgb = 12'hF80;
            default: rgb = 12'h8F0;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_box_motion.sv
// Per-frame motion of the bouncing box. Position, direction and colour only
// change in the two update cycles that follow entry into vertical blanking.
module vga_box_motion
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 64,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] haddress_i,
    input  logic [9:0] vaddress_i,
    input  logic       en_i,
    output logic [9:0] box_x_o,
    output logic [9:0] box_y_o,
    output logic [2:0] colour_o,
    output logic       frame_tick_o
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [9:0]  STEP_N = 10'(STEP);
    localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  X_INIT = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  Y_INIT = 10'((V_ACTIVE - BOX_SIZE) / 2);

    motion_state_e state_q, state_d;
    logic [9:0]    box_x_q, box_x_d, box_y_q, box_y_d;
    logic          dx_q, dx_d, dy_q, dy_d;        // 0 = increasing, 1 = decreasing
    logic [2:0]    colour_q, colour_d;
    logic          bounce_x_q, bounce_x_d;
    logic          bounce_y;

    always_comb begin
        state_d    = state_q;
        box_x_d    = box_x_q;
        box_y_d    = box_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        colour_d   = colour_q;
        bounce_x_d = bounce_x_q;
        bounce_y   = 1'b0;
        case (state_q)
            WAIT_VBLANK: begin
                if (vaddress_i == 10'(V_ACTIVE) && haddress_i == 10'd0)
                    state_d = UPDATE_X;
            end
            UPDATE_X: begin
                state_d    = UPDATE_Y;
                bounce_x_d = 1'b0;
                if (en_i) begin
                    if (!dx_q) begin
                        if ({1'b0, box_x_q} + BOX_W + STEP_W > H_LIM) begin
                            box_x_d    = X_MAX;
                            dx_d       = 1'b1;
                            bounce_x_d = 1'b1;
                        end else begin
                            box_x_d = box_x_q + STEP_N;
                        end
                    end else begin
                        if ({1'b0, box_x_q} < STEP_W) begin
                            box_x_d    = 10'd0;
                            dx_d       = 1'b0;
                            bounce_x_d = 1'b1;
                        end else begin
                            box_x_d = box_x_q - STEP_N;
                        end
                    end
                end
            end
            UPDATE_Y: begin
                state_d = WAIT_ACTIVE;
                if (en_i) begin
                    if (!dy_q) begin
                        if ({1'b0, box_y_q} + BOX_W + STEP_W > V_LIM) begin
                            box_y_d  = Y_MAX;
                            dy_d     = 1'b1;
                            bounce_y = 1'b1;
                        end else begin
                            box_y_d = box_y_q + STEP_N;
                        end
                    end else begin
                        if ({1'b0, box_y_q} < STEP_W) begin
                            box_y_d  = 10'd0;
                            dy_d     = 1'b0;
                            bounce_y = 1'b1;
                        end else begin
                            box_y_d = box_y_q - STEP_N;
                        end
                    end
                    // A corner hit still advances the colour only once
                    if (bounce_x_q || bounce_y)
                        colour_d = colour_q + 3'd1;
                end
            end
            WAIT_ACTIVE: begin
                if (vaddress_i < 10'(V_ACTIVE))
                    state_d = WAIT_VBLANK;
            end
            default: state_d = WAIT_VBLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_VBLANK;
            box_x_q    <= X_INIT;
            box_y_q    <= Y_INIT;
            dx_q       <= 1'b0;
            dy_q       <= 1'b0;
            colour_q   <= 3'd0;
            bounce_x_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            colour_q   <= colour_d;
            bounce_x_q <= bounce_x_d;
        end
    end

    assign box_x_o      = box_x_q;
    assign box_y_o      = box_y_q;
    assign colour_o     = colour_q;
    assign frame_tick_o = (state_q == UPDATE_X);

endmodule

// File: rtl/vga_box_render.sv
// Two-stage pixel pipeline: checkerboard background plus a bordered bouncing
// box, with the sync inputs delayed by the same two cycles as RGB.
module vga_box_render
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 64,
    parameter int BORDER   = 2,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] haddress,
    input  logic [9:0] vaddress,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       en,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);
    localparam logic [10:0] BRD_W = 11'(BORDER);

    logic [9:0] box_x, box_y;
    logic [2:0] colour;

    vga_box_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_motion (
        .clk          (clk),
        .rst_n        (rst_n),
        .haddress_i   (haddress),
        .vaddress_i   (vaddress),
        .en_i         (en),
        .box_x_o      (box_x),
        .box_y_o      (box_y),
        .colour_o     (colour),
        .frame_tick_o (frame_tick)
    );

    // Stage 1: classify the pixel; compares are 11 bits wide so box_x+BOX_SIZE cannot wrap
    logic [10:0] h_ext, v_ext, bx_ext, by_ext;
    logic        in_x, in_y, edge_x, edge_y;
    logic        active_d, inside_d, border_d, checker_d;
    logic        active_q, inside_q, border_q, checker_q;
    logic [2:0]  colour_s1_q;
    logic        hsync_s1_q, vsync_s1_q;

    assign h_ext  = {1'b0, haddress};
    assign v_ext  = {1'b0, vaddress};
    assign bx_ext = {1'b0, box_x};
    assign by_ext = {1'b0, box_y};

    assign in_x   = (h_ext >= bx_ext) && (h_ext < bx_ext + BOX_W);
    assign in_y   = (v_ext >= by_ext) && (v_ext < by_ext + BOX_W);
    assign edge_x = (h_ext < bx_ext + BRD_W) || (h_ext >= bx_ext + BOX_W - BRD_W);
    assign edge_y = (v_ext < by_ext + BRD_W) || (v_ext >= by_ext + BOX_W - BRD_W);

    assign active_d  = (haddress < 10'(H_ACTIVE)) && (vaddress < 10'(V_ACTIVE));
    assign inside_d  = in_x && in_y;
    assign border_d  = in_x && in_y && (edge_x || edge_y);
    assign checker_d = haddress[5] ^ vaddress[5];

    // Stage 2: priority colour select
    logic [11:0] rgb_d, rgb_q;
    logic        hsync_q, vsync_q;

    always_comb begin
        rgb_d = 12'h000;
        if (active_q) begin
            if (border_q)
                rgb_d = BORDER_RGB;
            else if (inside_q)
                rgb_d = palette_rgb(colour_s1_q);
            else
                rgb_d = checker_q ? BG_LIGHT : BG_DARK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            inside_q    <= 1'b0;
            border_q    <= 1'b0;
            checker_q   <= 1'b0;
            colour_s1_q <= 3'd0;
            hsync_s1_q  <= 1'b1;
            vsync_s1_q  <= 1'b1;
            rgb_q       <= 12'h000;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            active_q    <= active_d;
            inside_q    <= inside_d;
            border_q    <= border_d;
            checker_q   <= checker_d;
            colour_s1_q <= colour;
            hsync_s1_q  <= hsync;
            vsync_s1_q  <= vsync;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_s1_q;
            vsync_q     <= vsync_s1_q;
        end
    end

    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

endmodule

// File: tb/tb_vga_box_render.sv
// Self-checking bench for vga_box_render: pixel vector table, randomized
// pixels against a reference model, frame-level motion, freeze and reset.
module tb_vga_box_render;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] haddress, vaddress;
    logic       hsync, vsync, en;
    logic [3:0] red, green, blue, red3, green3, blue3;
    logic       hsync_out, vsync_out, frame_tick;
    logic       hsync_out3, vsync_out3, frame_tick3;

    always #5 clk = ~clk;

    vga_box_render dut (
        .clk(clk), .rst_n(rst_n), .haddress(haddress), .vaddress(vaddress),
        .hsync(hsync), .vsync(vsync), .en(en),
        .red(red), .green(green), .blue(blue),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
    );

    vga_box_render #(.STEP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .haddress(haddress), .vaddress(vaddress),
        .hsync(hsync), .vsync(vsync), .en(en),
        .red(red3), .green(green3), .blue(blue3),
        .hsync_out(hsync_out3), .vsync_out(vsync_out3), .frame_tick(frame_tick3)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                             12'h0FF, 12'hF0F, 12'hF80, 12'h8F0};

    // Reference model, index 0 = STEP 2 instance, index 1 = STEP 3 instance
    int mstep [2] = '{2, 3};
    int mx [2], my [2], mdx [2], mdy [2], mcol [2];

    typedef struct {
        int         h;
        int         v;
        bit         hs;
        bit         vs;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        bit          hs;
        bit          vs;
    } exp_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input bit hs, input bit vs);
        haddress = 10'(h);
        vaddress = 10'(v);
        hsync    = hs;
        vsync    = vs;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 288; my[k] = 208; mdx[k] = 1; mdy[k] = 1; mcol[k] = 0;
        end
    endfunction

    function automatic void model_frame(input bit move);
        bit bx, by;
        if (!move) return;
        for (int k = 0; k < 2; k++) begin
            bx = 0; by = 0;
            if (mdx[k] > 0) begin
                if (mx[k] + 64 + mstep[k] > 640) begin mx[k] = 576; mdx[k] = -1; bx = 1; end
                else mx[k] += mstep[k];
            end else begin
                if (mx[k] < mstep[k]) begin mx[k] = 0; mdx[k] = 1; bx = 1; end
                else mx[k] -= mstep[k];
            end
            if (mdy[k] > 0) begin
                if (my[k] + 64 + mstep[k] > 480) begin my[k] = 416; mdy[k] = -1; by = 1; end
                else my[k] += mstep[k];
            end else begin
                if (my[k] < mstep[k]) begin my[k] = 0; mdy[k] = 1; by = 1; end
                else my[k] -= mstep[k];
            end
            if (bx || by) mcol[k] = (mcol[k] + 1) % 8;
        end
    endfunction

    function automatic logic [11:0] ref_pixel(input int h, input int v);
        int bx = mx[0];
        int by = my[0];
        if (h >= 640 || v >= 480) return 12'h000;
        if (h >= bx && h < bx + 64 && v >= by && v < by + 64) begin
            if (h - bx < 2 || bx + 63 - h < 2 || v - by < 2 || by + 63 - v < 2)
                return 12'hFFF;
            return pal[mcol[0]];
        end
        return (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 12'h222 : 12'h111;
    endfunction

    task automatic check_box(input string tag);
        check({tag, " box_x"},  int'(dut.u_motion.box_x_q),   mx[0]);
        check({tag, " box_y"},  int'(dut.u_motion.box_y_q),   my[0]);
        check({tag, " colour"}, int'(dut.u_motion.colour_q),  mcol[0]);
        check({tag, " box_x step3"}, int'(dut3.u_motion.box_x_q), mx[1]);
        check({tag, " box_y step3"}, int'(dut3.u_motion.box_y_q), my[1]);
    endtask

    // Enter vblank, hold inside it, then return to active video; counts ticks
    task automatic do_frame(input int hold, output int ticks);
        ticks = 0;
        drive(0, 480, 1, 0);
        step();
        if (frame_tick) ticks++;
        drive(0, 490, 1, 0);
        for (int c = 0; c < hold; c++) begin
            step();
            if (frame_tick) ticks++;
        end
        drive(0, 0, 1, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            if (frame_tick) ticks++;
        end
        model_frame(en);
    endtask

    task automatic random_pixels(input int n);
        exp_t q[$];
        exp_t e, got;
        int h, v;
        bit hs, vs;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                if ($urandom_range(1, 0) == 1) begin
                    h = mx[0] - 4 + int'($urandom_range(71, 0));
                    v = my[0] - 4 + int'($urandom_range(71, 0));
                    if (h < 0) h = 0;
                    if (v < 0) v = 0;
                end else begin
                    h = int'($urandom_range(799, 0));
                    v = int'($urandom_range(479, 0));
                end
                hs = 1'($urandom_range(1, 0));
                vs = 1'($urandom_range(1, 0));
                drive(h, v, hs, vs);
                e.rgb = ref_pixel(h, v);
                e.hs  = hs;
                e.vs  = vs;
                q.push_back(e);
            end
            step();
            if (i >= 1) begin
                got = q.pop_front();
                check("rand rgb", int'({red, green, blue}), int'(got.rgb));
                check("rand hsync_out", int'(hsync_out), int'(got.hs));
                check("rand vsync_out", int'(vsync_out), int'(got.vs));
            end
        end
    endtask

    vec_t vt [10];
    int   ticks;
    int   total;
    int   hold_x, hold_y;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();

        // Reset state
        for (int c = 0; c < 5; c++) step();
        check("reset rgb", int'({red, green, blue}), 0);
        check("reset hsync_out", int'(hsync_out), 1);
        check("reset vsync_out", int'(vsync_out), 1);
        check("reset frame_tick", int'(frame_tick), 0);
        check_box("reset");

        // Vector table, box at its reset position and frozen
        vt[0] = '{0,   0,   0, 1, 12'h111};
        vt[1] = '{32,  0,   1, 0, 12'h222};
        vt[2] = '{700, 0,   1, 1, 12'h000};
        vt[3] = '{288, 208, 0, 0, 12'hFFF};
        vt[4] = '{289, 209, 1, 1, 12'hFFF};
        vt[5] = '{290, 210, 1, 0, 12'hF00};
        vt[6] = '{320, 240, 0, 1, 12'hF00};
        vt[7] = '{352, 240, 1, 1, 12'h111};
        vt[8] = '{351, 271, 0, 0, 12'hFFF};
        vt[9] = '{5,   480, 1, 1, 12'h000};
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) drive(vt[i].h, vt[i].v, vt[i].hs, vt[i].vs);
            step();
            if (i >= 1) begin
                check($sformatf("vec%0d rgb", i - 1), int'({red, green, blue}), int'(vt[i-1].rgb));
                check($sformatf("vec%0d hsync_out", i - 1), int'(hsync_out), int'(vt[i-1].hs));
                check($sformatf("vec%0d vsync_out", i - 1), int'(vsync_out), int'(vt[i-1].vs));
            end
        end

        random_pixels(300);

        // One frame with a long vblank: exactly one tick, one update
        en = 1'b1;
        do_frame(2000, ticks);
        check("long vblank ticks", ticks, 1);
        check("frame1 box_x", int'(dut.u_motion.box_x_q), 290);
        check("frame1 box_y", int'(dut.u_motion.box_y_q), 210);
        check_box("frame1");

        // Many frames through right/bottom bounces and colour changes
        for (int f = 0; f < 150; f++) begin
            do_frame(3, ticks);
            check($sformatf("frame%0d ticks", f + 2), ticks, 1);
            check_box($sformatf("frame%0d", f + 2));
        end

        en = 1'b0;
        random_pixels(300);

        // Freeze: ticks continue, nothing moves
        hold_x = mx[0];
        hold_y = my[0];
        total  = 0;
        for (int f = 0; f < 3; f++) begin
            do_frame(3, ticks);
            total += ticks;
        end
        check("freeze ticks", total, 3);
        check("freeze box_x", int'(dut.u_motion.box_x_q), hold_x);
        check("freeze box_y", int'(dut.u_motion.box_y_q), hold_y);

        // Reset mid-line
        en = 1'b1;
        drive(100, 100, 0, 0);
        step();
        step();
        rst_n = 1'b0;
        step();
        model_reset();
        check("midreset rgb", int'({red, green, blue}), 0);
        check("midreset hsync_out", int'(hsync_out), 1);
        check_box("midreset");
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post-reset rgb", int'({red, green, blue}), int'(ref_pixel(100, 100)));
        do_frame(3, ticks);
        check("post-reset ticks", ticks, 1);
        check_box("post-reset frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
